// File: rtl/counter_checker_pkg.sv
// Shared types and default parameters for the counter_checker block.
// Build option: COUNTER_CHECKER_WRAP_EN adds the wrap pulse output.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int WIDTH_DEF    = 3;
  localparam int LOCK_CNT_DEF = 2;
  localparam int ERRW_DEF     = 8;

  // Run counter width covers the full 1..15 LOCK_CNT range.
  localparam int RUN_W = 4;

endpackage

// File: rtl/cc_sat_cnt.sv
// Saturating event counter: increments once per cycle while inc is high,
// holding at all-ones instead of wrapping.
module cc_sat_cnt
  import counter_checker_pkg::*;
#(
  parameter int ERRW = ERRW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [ERRW-1:0] cnt
);

  localparam logic [ERRW-1:0] CNT_MAX = '1;

  logic [ERRW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/counter_checker.sv
// Monitors a toggle-enabled up-counter, locks after LOCK_CNT correct steps
// and flags mismatches while locked. Option COUNTER_CHECKER_WRAP_EN adds wrap.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERRW     = ERRW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] expected
`ifdef COUNTER_CHECKER_WRAP_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  state_e           state_q;
  logic [RUN_W-1:0] run_q;
  logic             locked_q;
  logic             err_q;
  logic             t_d;
  logic [WIDTH-1:0] q_d;

  logic             step_ok;
  logic             fault;
  logic [RUN_W-1:0] run_inc;

  // The prediction depends only on the previous sample, so a change of t
  // affects the following edge and nothing earlier.
  assign expected = q_d + WIDTH'(t_d);
  assign step_ok  = (q_in == expected);
  assign fault    = (state_q == LOCKED) && !step_ok;
  assign run_inc  = run_q + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      t_d      <= 1'b0;
      q_d      <= '0;
    end else begin
      t_d   <= t;
      q_d   <= q_in;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= SEARCH;
          run_q   <= '0;
        end
        SEARCH: begin
          if (step_ok) begin
            run_q <= run_inc;
            if (run_inc == LOCK_RUN) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else begin
            run_q <= '0;
          end
        end
        LOCKED: begin
          if (!step_ok) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            run_q    <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
          run_q    <= '0;
        end
      endcase
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

  // Increments on the same edge that raises err, so both are seen together.
  cc_sat_cnt #(
    .ERRW(ERRW)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fault),
    .cnt (err_cnt)
  );

`ifdef COUNTER_CHECKER_WRAP_EN
  logic wrap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= (state_q == LOCKED) && step_ok && t_d && (&q_d);
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed vector table, reset and
// saturation sequences, then randomized traffic against a streak-based model.
module tb_counter_checker;

  localparam int W    = 3;
  localparam int LOCK = 2;
  localparam int MODN = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         t;
  logic [W-1:0] q_in;

  logic         locked, err, locked_s, err_s;
  logic [7:0]   err_cnt;
  logic [1:0]   err_cnt_s;
  logic [W-1:0] expected, expected_s;
`ifdef COUNTER_CHECKER_WRAP_EN
  logic         wrap, wrap_s;
`endif

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERRW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .t        (t),
    .q_in     (q_in),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .expected (expected)
`ifdef COUNTER_CHECKER_WRAP_EN
    ,
    .wrap     (wrap)
`endif
  );

  counter_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERRW(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .t        (t),
    .q_in     (q_in),
    .locked   (locked_s),
    .err      (err_s),
    .err_cnt  (err_cnt_s),
    .expected (expected_s)
`ifdef COUNTER_CHECKER_WRAP_EN
    ,
    .wrap     (wrap_s)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a step is judged against the previous sample; the block
  // is locked whenever the current streak of correct steps is >= LOCK.
  bit m_have, m_err, m_wrap;
  int m_q, m_t, m_run, m_errs;

  function automatic void m_reset();
    m_have = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    m_q = 0; m_t = 0; m_run = 0; m_errs = 0;
  endfunction

  function automatic void m_step(input int tv, input int qv);
    int pred;
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (!m_have) begin
      m_have = 1'b1;
    end else begin
      pred = (m_q + m_t) % MODN;
      if (qv == pred) begin
        m_wrap = (m_run >= LOCK) && (qv == 0) && (m_t == 1);
        m_run++;
      end else begin
        if (m_run >= LOCK) begin
          m_err = 1'b1;
          m_errs++;
        end
        m_run = 0;
      end
    end
    m_q = qv;
    m_t = tv;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".locked"},   locked,    (m_have && m_run >= LOCK));
    check({tag, ".err"},      err,       m_err);
    check({tag, ".expected"}, expected,  (m_q + m_t) % MODN);
    check({tag, ".err_cnt"},  err_cnt,   (m_errs > 255) ? 255 : m_errs);
    check({tag, ".err_cnt2"}, err_cnt_s, (m_errs > 3) ? 3 : m_errs);
`ifdef COUNTER_CHECKER_WRAP_EN
    check({tag, ".wrap"},     wrap,      m_wrap);
`endif
  endtask

  task automatic step(input int tv, input int qv, input string tag);
    t    = (tv != 0);
    q_in = W'(qv);
    @(posedge clk);
    m_step(tv, qv);
    #1;
    check_model(tag);
  endtask

  // True value of the monitored counter.
  int cnt_m;

  task automatic run_counter(input int n, input int tv, input string tag);
    for (int i = 0; i < n; i++) begin
      step(tv, cnt_m, tag);
      cnt_m = (cnt_m + tv) % MODN;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".locked"},   locked,     0);
    check({tag, ".err"},      err,        0);
    check({tag, ".err_cnt"},  err_cnt,    0);
    check({tag, ".expected"}, expected,   0);
    check({tag, ".err_cnt2"}, err_cnt_s,  0);
    check({tag, ".expected2"}, expected_s, 0);
`ifdef COUNTER_CHECKER_WRAP_EN
    check({tag, ".wrap"},     wrap,       0);
`endif
  endtask

  typedef struct {
    bit tv;
    int qv;
    bit lk;
    bit er;
    int ex;
    int ec;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input bit tv, input int qv, input bit lk,
                              input bit er, input int ex, input int ec);
    vec_t v;
    v.tv = tv; v.qv = qv; v.lk = lk; v.er = er; v.ex = ex; v.ec = ec;
    vq.push_back(v);
  endfunction

  initial begin
    // Lock, wrap, a 3->6 glitch, relock, then t low for five cycles at 5.
    add(1, 0, 0, 0, 1, 0); add(1, 1, 0, 0, 2, 0); add(1, 2, 1, 0, 3, 0);
    add(1, 3, 1, 0, 4, 0); add(1, 4, 1, 0, 5, 0); add(1, 5, 1, 0, 6, 0);
    add(1, 6, 1, 0, 7, 0); add(1, 7, 1, 0, 0, 0); add(1, 0, 1, 0, 1, 0);
    add(1, 1, 1, 0, 2, 0); add(1, 2, 1, 0, 3, 0); add(1, 6, 0, 1, 7, 1);
    add(1, 4, 0, 0, 5, 1); add(1, 5, 0, 0, 6, 1); add(1, 6, 1, 0, 7, 1);
    add(1, 7, 1, 0, 0, 1); add(1, 0, 1, 0, 1, 1); add(1, 1, 1, 0, 2, 1);
    add(1, 2, 1, 0, 3, 1); add(1, 3, 1, 0, 4, 1); add(1, 4, 1, 0, 5, 1);
    add(0, 5, 1, 0, 5, 1); add(0, 5, 1, 0, 5, 1); add(0, 5, 1, 0, 5, 1);
    add(0, 5, 1, 0, 5, 1); add(0, 5, 1, 0, 5, 1); add(1, 5, 1, 0, 6, 1);
    add(1, 6, 1, 0, 7, 1);

    rst  = 1'b0;
    t    = 1'b1;
    q_in = '0;
    m_reset();
    #12;
    check_all_zero("reset");
    rst = 1'b1;

    foreach (vq[i]) begin
      t    = vq[i].tv;
      q_in = W'(vq[i].qv);
      @(posedge clk);
      m_step(vq[i].tv, vq[i].qv);
      #1;
      check($sformatf("vec%0d.locked", i),   locked,    vq[i].lk);
      check($sformatf("vec%0d.err", i),      err,       vq[i].er);
      check($sformatf("vec%0d.expected", i), expected,  vq[i].ex);
      check($sformatf("vec%0d.err_cnt", i),  err_cnt,   vq[i].ec);
      check($sformatf("vec%0d.err_cnt2", i), err_cnt_s, (vq[i].ec > 3) ? 3 : vq[i].ec);
`ifdef COUNTER_CHECKER_WRAP_EN
      check($sformatf("vec%0d.wrap", i),     wrap,      (i == 8 || i == 16));
`endif
    end

    // Fault-free run across several wrap points.
    cnt_m = 7;
    run_counter(20, 1, "clean");

    // Asynchronous reset mid-cycle, then relock from scratch.
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    #3;
    rst = 1'b1;
    m_reset();
    cnt_m = 2;
    run_counter(2, 1, "relock");
    check("relock.not_yet", locked, 0);
    run_counter(1, 1, "relock");
    check("relock.third_edge", locked, 1);

    // Five faults while locked: the 2-bit counter must stop at 3.
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 8 && !(m_run >= LOCK); k++) run_counter(1, 1, "sat.wait");
      check("sat.locked_before_fault", locked, 1);
      step(1, (cnt_m + 3) % MODN, "sat.fault");
      cnt_m = (cnt_m + 1) % MODN;
    end
    run_counter(4, 1, "sat.tail");
    check("sat.err_cnt8", err_cnt, 5);
    check("sat.err_cnt2", err_cnt_s, 3);

    // Randomized traffic: random t, occasional corrupted samples.
    for (int i = 0; i < 400; i++) begin
      int tv, qv;
      tv = int'($urandom_range(0, 1));
      qv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MODN - 1)) : cnt_m;
      step(tv, qv, "rand");
      cnt_m = (cnt_m + tv) % MODN;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 3, bit width of the monitored counter value.
REQ-002 Parameter LOCK_CNT, default 2, consecutive correct steps required to enter LOCKED; legal range 1..15.
REQ-003 Parameter ERRW, default 8, width of the error counter.
REQ-004 clk  input  1  rising-edge clock shared with the monitored counter.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 t  input  1  count-enable as driven to the monitored counter.
REQ-007 q_in  input  WIDTH  monitored counter output.
REQ-008 locked  output  1  high while the checker is in LOCKED.
REQ-009 err  output  1  one-cycle pulse on a mismatch detected in LOCKED.
REQ-010 err_cnt  output  ERRW  saturating count of err pulses.
REQ-011 expected  output  WIDTH  value predicted for the next q_in sample.

Function
REQ-012 The block SHALL sample t and q_in on every rising clk edge into registers t_d and q_d.
REQ-013 Prediction, modulo 2^WIDTH: expected = q_d + 1 when t_d = 1, and expected = q_d when t_d = 0.
REQ-014 States SHALL be IDLE, SEARCH and LOCKED; a step is correct when q_in == expected at the edge.
REQ-015 IDLE: the first edge after reset release SHALL capture q_in and t and move to SEARCH without comparing.
REQ-016 SEARCH: each correct step SHALL increment match_run; a wrong step SHALL clear match_run and resync from q_in; match_run reaching LOCK_CNT SHALL move to LOCKED on that same edge.
REQ-017 LOCKED: a wrong step SHALL pulse err for exactly one cycle (registered, asserted the cycle after the failing edge), increment err_cnt, clear match_run, resync from q_in and move to SEARCH.
REQ-018 err_cnt SHALL saturate at 2^ERRW-1 and never wrap.
REQ-019 Wrap-around (all-ones to zero with t_d = 1) SHALL be a correct step and SHALL NOT raise err.
REQ-020 t toggling at any cycle SHALL only change the prediction for the following edge; there is no minimum hold time.
REQ-021 locked SHALL deassert on the same edge that sets err.

Reset
REQ-022 rst low SHALL immediately force state IDLE, locked 0, err 0, err_cnt 0, expected 0, match_run 0, t_d 0, q_d 0.
REQ-023 Reset asserted mid-operation SHALL discard all history; after release the block restarts at REQ-015.

Configuration
REQ-024 Macro COUNTER_CHECKER_WRAP_EN: when defined, add output wrap (1 bit), a one-cycle registered pulse for each correct all-ones-to-zero step while in LOCKED; reset value 0.
REQ-025 When COUNTER_CHECKER_WRAP_EN is undefined, the wrap port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package counter_checker_pkg SHALL hold the state enum (IDLE, SEARCH, LOCKED) and the default parameter constants.
REQ-027 The saturating error counter SHALL be the sub-module cc_sat_cnt (parameter ERRW; ports clk, rst, inc, cnt).

Verification
REQ-028 A bench SHALL cover each of the following directed scenarios:
- Reset released at 12 ns, t = 1, fault-free 3-bit counter -> locked = 1 at the third edge after release; err is never asserted over 200 ns; expected tracks q_in + 1.
- Locked, with q_in forced from 3 to 6 for one cycle -> a single err pulse, err_cnt = 1, locked = 0, then locked = 1 again after LOCK_CNT correct steps.
- t = 0 for 5 cycles while locked, q_in holding at 5 -> no err, and expected stays 5.
- Locked through the 7 -> 0 step -> err = 0; with COUNTER_CHECKER_WRAP_EN defined, wrap pulses once per pass.
- ERRW = 2 with 5 injected faults -> err_cnt stops at 3.
- rst pulsed low mid-count -> all outputs are 0 asynchronously, and the block relocks per REQ-015/REQ-016.
